// File: rtl/mem_line_to_word_adapter_if.sv
// Val/rdy message channel used on every side of the line-to-word adapter.
// The master drives msg/val and the slave drives rdy.
interface mem_line_to_word_adapter_if #(
   parameter int unsigned W = 1
);
   logic [W-1:0] msg;
   logic         val;
   logic         rdy;

   modport master (output msg, output val, input rdy);
   modport slave  (input msg, input val, output rdy);
endinterface

// File: rtl/mem_line_to_word_adapter.sv
// Serialises one cache-line memory request into four word requests and gathers the read words back into a line.
// Define MEM_LINE_ADAPTER_PIPELINE_EN to allow up to four outstanding word requests (BUSY state) instead of strict REQ/WAIT alternation.
module mem_line_to_word_adapter #(
   parameter int unsigned abw = 32,
   parameter int unsigned clw = 128,
   parameter int unsigned dbw = 32,
   parameter int unsigned o   = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   mem_line_to_word_adapter_if.slave         linereq,
   mem_line_to_word_adapter_if.master        lineresp,
   mem_line_to_word_adapter_if.master        wordreq,
   mem_line_to_word_adapter_if.slave         wordresp
);
   localparam int unsigned NW      = 4;
   localparam int unsigned LLW     = $clog2(clw / 8);
   localparam int unsigned WLW     = $clog2(dbw / 8);
   localparam int unsigned WRESP_W = 3 + o + WLW + dbw;
   localparam logic [2:0]  TYPE_WRITE = 3'd1;

`ifdef MEM_LINE_ADAPTER_PIPELINE_EN
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
`else
   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
`endif

   state_t                  state_q;
   logic                    lreq_rdy_q, lresp_val_q, wreq_val_q, wresp_rdy_q;
   logic [2:0]              req_cnt_q, resp_cnt_q;
   logic [2:0]              req_cnt_d, resp_cnt_d;
   logic [2:0]              type_q;
   logic [o-1:0]            opq_q;
   logic [abw-1:0]          addr_q;
   logic [NW-1:0][dbw-1:0]  data_q, buf_q, buf_d;

   // Line request fields: {type, opaque, addr, len, data}
   logic [2:0]              lreq_type;
   logic [o-1:0]            lreq_opq;
   logic [abw-1:0]          lreq_addr;
   logic [clw-1:0]          lreq_data;
   logic [dbw-1:0]          wresp_data;
   logic                    unused_fields;

   assign lreq_type  = linereq.msg[clw+LLW+abw+o +: 3];
   assign lreq_opq   = linereq.msg[clw+LLW+abw +: o];
   assign lreq_addr  = linereq.msg[clw+LLW +: abw];
   assign lreq_data  = linereq.msg[clw-1:0];
   assign wresp_data = wordresp.msg[dbw-1:0];
   // Word response type/opaque/len are not checked; the line len field is ignored.
   assign unused_fields = ^{linereq.msg[clw +: LLW], wordresp.msg[WRESP_W-1:dbw]};

   logic                    is_wr;
   logic                    wreq_fire, wresp_fire, lreq_fire, lresp_fire;
   logic [abw-1:0]          word_addr;
   logic [o-1:0]            word_opq;
   logic [dbw-1:0]          word_data;
   logic [clw-1:0]          lresp_data;

   assign is_wr      = (type_q == TYPE_WRITE);
   assign wreq_fire  = wreq_val_q & wordreq.rdy;
   assign wresp_fire = wordresp.val & wresp_rdy_q;
   assign lreq_fire  = linereq.val & lreq_rdy_q;
   assign lresp_fire = lresp_val_q & lineresp.rdy;
   assign req_cnt_d  = req_cnt_q + 3'd1;
   assign resp_cnt_d = resp_cnt_q + 3'd1;

   always_comb begin
      buf_d = buf_q;
      buf_d[resp_cnt_q[1:0]] = wresp_data;
   end

   // Base address has its low 4 bits cleared, so the word offset never carries out of the line.
   assign word_addr  = addr_q + {{(abw-4){1'b0}}, req_cnt_q[1:0], 2'b00};
   assign word_opq   = {{(o-2){1'b0}}, req_cnt_q[1:0]};
   assign word_data  = is_wr ? data_q[req_cnt_q[1:0]] : '0;
   assign lresp_data = is_wr ? '0 : buf_q;

   assign linereq.rdy  = lreq_rdy_q;
   assign lineresp.val = lresp_val_q;
   assign lineresp.msg = {type_q, opq_q, {LLW{1'b0}}, lresp_data};
   assign wordreq.val  = wreq_val_q;
   assign wordreq.msg  = {type_q, word_opq, word_addr, {WLW{1'b0}}, word_data};
   assign wordresp.rdy = wresp_rdy_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         lreq_rdy_q  <= 1'b1;
         lresp_val_q <= 1'b0;
         wreq_val_q  <= 1'b0;
         wresp_rdy_q <= 1'b1;
         req_cnt_q   <= '0;
         resp_cnt_q  <= '0;
         type_q      <= '0;
         opq_q       <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         buf_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (lreq_fire) begin
                  type_q      <= lreq_type;
                  opq_q       <= lreq_opq;
                  addr_q      <= {lreq_addr[abw-1:4], 4'h0};
                  data_q      <= lreq_data;
                  req_cnt_q   <= '0;
                  resp_cnt_q  <= '0;
                  lreq_rdy_q  <= 1'b0;
                  wreq_val_q  <= 1'b1;
`ifdef MEM_LINE_ADAPTER_PIPELINE_EN
                  state_q     <= BUSY;
`else
                  state_q     <= REQ;
                  wresp_rdy_q <= 1'b0;
`endif
               end
            end
`ifdef MEM_LINE_ADAPTER_PIPELINE_EN
            BUSY: begin
               if (wreq_fire) begin
                  req_cnt_q <= req_cnt_d;
                  if (req_cnt_d[2]) wreq_val_q <= 1'b0;
               end
               if (wresp_fire) begin
                  if (!is_wr) buf_q <= buf_d;
                  resp_cnt_q <= resp_cnt_d;
                  if (resp_cnt_d[2]) begin
                     state_q     <= RESP;
                     wresp_rdy_q <= 1'b0;
                     lresp_val_q <= 1'b1;
                  end
               end
            end
`else
            REQ: begin
               if (wreq_fire) begin
                  req_cnt_q   <= req_cnt_d;
                  wreq_val_q  <= 1'b0;
                  wresp_rdy_q <= 1'b1;
                  state_q     <= WAIT;
               end
            end
            WAIT: begin
               if (wresp_fire) begin
                  if (!is_wr) buf_q <= buf_d;
                  resp_cnt_q  <= resp_cnt_d;
                  wresp_rdy_q <= 1'b0;
                  if (resp_cnt_d[2] && req_cnt_q[2]) begin
                     state_q     <= RESP;
                     lresp_val_q <= 1'b1;
                  end else begin
                     state_q    <= REQ;
                     wreq_val_q <= 1'b1;
                  end
               end
            end
`endif
            RESP: begin
               if (lresp_fire) begin
                  state_q     <= IDLE;
                  lresp_val_q <= 1'b0;
                  lreq_rdy_q  <= 1'b1;
                  wresp_rdy_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_line_to_word_adapter.sv
// Randomised self-checking bench for mem_line_to_word_adapter: word memory model plus line-level reference model.
module tb_mem_line_to_word_adapter;
   localparam int unsigned LREQ_W  = 175;
   localparam int unsigned LRESP_W = 143;
   localparam int unsigned WREQ_W  = 77;
   localparam int unsigned WRESP_W = 45;
`ifdef MEM_LINE_ADAPTER_PIPELINE_EN
   localparam int LAT = 6;
`else
   localparam int LAT = 9;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_line_to_word_adapter_if #(.W(LREQ_W))  linereq ();
   mem_line_to_word_adapter_if #(.W(LRESP_W)) lineresp ();
   mem_line_to_word_adapter_if #(.W(WREQ_W))  wordreq ();
   mem_line_to_word_adapter_if #(.W(WRESP_W)) wordresp ();

   mem_line_to_word_adapter #(.abw(32), .clw(128), .dbw(32), .o(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .linereq  (linereq),
      .lineresp (lineresp),
      .wordreq  (wordreq),
      .wordresp (wordresp)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [LREQ_W-1:0] mk_lreq(input logic [2:0] t, input logic [7:0] op,
                                                 input logic [31:0] a, input logic [127:0] d);
      return {t, op, a, 4'h0, d};
   endfunction
   function automatic logic [LRESP_W-1:0] mk_lresp(input logic [2:0] t, input logic [7:0] op, input logic [127:0] d);
      return {t, op, 4'h0, d};
   endfunction
   function automatic logic [WREQ_W-1:0] mk_wreq(input logic [2:0] t, input logic [7:0] op,
                                                 input logic [31:0] a, input logic [31:0] d);
      return {t, op, a, 2'b00, d};
   endfunction
   function automatic logic [WRESP_W-1:0] mk_wresp(input logic [2:0] t, input logic [7:0] op, input logic [31:0] d);
      return {t, op, 2'b00, d};
   endfunction

   logic [31:0] mem [logic [31:0]];
   function automatic logic [31:0] rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   logic [LREQ_W-1:0]  line_q [$];
   logic [WREQ_W-1:0]  exp_w_q [$];
   logic [LRESP_W-1:0] exp_l_q [$];
   logic [WRESP_W-1:0] resp_q [$];
   int                 resp_dly [$];
   logic [31:0]        wreq_addr_log [$];
   int                 wreq_fire_cyc [$];

   int cyc = 0, inflight = 0, n_lresp = 0;
   int acc_cyc = 0, first_val_cyc = -1, last_lresp_cyc = -1;
   int wreq_line = 0, wresp_line = 0;
   int wstall_word = -1, wstall_left = 0, lstall_left = 0;
   bit rand_bp = 1'b0, rand_dly = 1'b0, chk_b2b = 1'b0;
   logic [127:0] last_ldata;
   logic [2:0]   last_ltype;
   logic [7:0]   last_lopq;

   // Expected words and line response follow directly from the line request and the current memory image.
   task automatic model_accept(input logic [LREQ_W-1:0] m);
      logic [2:0]   t;
      logic [31:0]  base, wa, wd;
      logic [127:0] d, line;
      t    = m[174:172];
      base = m[163:132] & ~32'hF;
      d    = m[127:0];
      line = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         wa = base + 4 * i;
         wd = (t == 3'd1) ? d[32*i +: 32] : 32'h0;
         exp_w_q.push_back(mk_wreq(t, 8'(i), wa, wd));
         line[32*i +: 32] = rd(wa);
      end
      exp_l_q.push_back(mk_lresp(t, m[171:164], (t == 3'd1) ? 128'h0 : line));
   endtask

   task automatic tick();
      bit lreq_f, lresp_f, wreq_f, wresp_f;
      logic [WREQ_W-1:0]  wm;
      logic [LREQ_W-1:0]  lm;
      logic [LRESP_W-1:0] rm;
      @(negedge clk);
      cyc++;
      linereq.val = (line_q.size() != 0);
      linereq.msg = (line_q.size() != 0) ? line_q[0] : '0;
      if (wordreq.val && wreq_line == wstall_word && wstall_left > 0) begin
         wordreq.rdy = 1'b0;
         wstall_left--;
      end else wordreq.rdy = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (lineresp.val && lstall_left > 0) begin
         lineresp.rdy = 1'b0;
         lstall_left--;
      end else lineresp.rdy = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (resp_q.size() != 0 && resp_dly[0] == 0) begin
         wordresp.val = 1'b1;
         wordresp.msg = resp_q[0];
      end else begin
         wordresp.val = 1'b0;
         wordresp.msg = '0;
         if (resp_q.size() != 0) resp_dly[0]--;
      end

      check("lreq_rdy", linereq.rdy, inflight == 0);
      if (inflight == 0) begin
         check("lresp_idle", lineresp.val, 1'b0);
         check("drain_rdy", wordresp.rdy, 1'b1);
      end
      if (exp_w_q.size() == 0) check("wreq_extra", wordreq.val, 1'b0);
      else if (wordreq.val) check("wreq_msg", wordreq.msg, exp_w_q[0]);
`ifndef MEM_LINE_ADAPTER_PIPELINE_EN
      if (wordreq.val) check("req_resp_rdy", wordresp.rdy, 1'b0);
`endif
      if (lineresp.val && exp_l_q.size() != 0) check("lresp_msg", lineresp.msg, exp_l_q[0]);
      if (lineresp.val && first_val_cyc < 0) first_val_cyc = cyc;

      lreq_f  = linereq.val && linereq.rdy;
      lresp_f = lineresp.val && lineresp.rdy;
      wreq_f  = wordreq.val && wordreq.rdy;
      wresp_f = wordresp.val && wordresp.rdy;

      if (wresp_f) begin
         void'(resp_q.pop_front());
         void'(resp_dly.pop_front());
         wresp_line++;
      end
      if (wreq_f) begin
         wm = wordreq.msg;
         if (exp_w_q.size() != 0) void'(exp_w_q.pop_front());
         wreq_line++;
         wreq_addr_log.push_back(wm[65:34]);
         wreq_fire_cyc.push_back(cyc);
         if (wm[76:74] == 3'd1) mem[wm[65:34]] = wm[31:0];
         resp_q.push_back(mk_wresp(wm[76:74], wm[73:66], (wm[76:74] == 3'd1) ? 32'h0 : rd(wm[65:34])));
         resp_dly.push_back(rand_dly ? int'($urandom_range(0, 2)) : 0);
      end
      if (lresp_f) begin
         rm = lineresp.msg;
         if (exp_l_q.size() != 0) void'(exp_l_q.pop_front());
         inflight--;
         n_lresp++;
         last_lresp_cyc = cyc;
         last_ldata = rm[127:0];
         last_ltype = rm[142:140];
         last_lopq  = rm[139:132];
      end
      if (lreq_f) begin
         if (chk_b2b && last_lresp_cyc >= 0) check("b2b_accept", cyc, last_lresp_cyc + 1);
         lm = line_q.pop_front();
         model_accept(lm);
         inflight++;
         acc_cyc = cyc;
         first_val_cyc = -1;
         wreq_line = 0;
         wresp_line = 0;
         wreq_addr_log.delete();
         wreq_fire_cyc.delete();
      end
   endtask

   task automatic run_lines(input int target, input int budget, input string tag);
      int n = 0;
      while (n_lresp < target && n < budget) begin
         tick();
         n++;
      end
      check(tag, n_lresp, target);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_rst_lresp_val", lineresp.val, 1'b0);
      check("mid_rst_lreq_rdy", linereq.rdy, 1'b1);
      check("mid_rst_wreq_val", wordreq.val, 1'b0);
      check("mid_rst_wresp_rdy", wordresp.rdy, 1'b1);
      exp_w_q.delete();
      exp_l_q.delete();
      inflight = 0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int n;
      logic [31:0] a, r;
      reset = 1'b1;
      linereq.val = 1'b0;  linereq.msg = '0;
      lineresp.rdy = 1'b0;
      wordreq.rdy = 1'b0;
      wordresp.val = 1'b0; wordresp.msg = '0;
      repeat (2) @(negedge clk);
      check("rst_lreq_rdy", linereq.rdy, 1'b1);
      check("rst_lresp_val", lineresp.val, 1'b0);
      check("rst_wreq_val", wordreq.val, 1'b0);
      check("rst_wresp_rdy", wordresp.rdy, 1'b1);
      reset = 1'b0;

      // Refill read
      mem[32'h1230] = 32'h11111111; mem[32'h1234] = 32'h22222222;
      mem[32'h1238] = 32'h33333333; mem[32'h123C] = 32'h44444444;
      line_q.push_back(mk_lreq(3'd0, 8'h5A, 32'h0000_1234, 128'h0));
      run_lines(1, 100, "refill_done");
      check("refill_lat", first_val_cyc - acc_cyc, LAT);
      check("refill_data", last_ldata, 128'h44444444_33333333_22222222_11111111);
      check("refill_opq", last_lopq, 8'h5A);
      check("refill_nreq", wreq_addr_log.size(), 4);
      for (int i = 0; i < 4 && i < wreq_addr_log.size(); i++) begin
         check("refill_addr", wreq_addr_log[i], 32'h1230 + 4 * i);
`ifdef MEM_LINE_ADAPTER_PIPELINE_EN
         check("pipe_req_cyc", wreq_fire_cyc[i], acc_cyc + 1 + i);
`endif
      end

      // Evict write
      line_q.push_back(mk_lreq(3'd1, 8'hC3, 32'h0000_0080,
                               128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA));
      run_lines(2, 100, "evict_done");
      check("evict_w0", rd(32'h80), 32'hAAAAAAAA);
      check("evict_w1", rd(32'h84), 32'hBBBBBBBB);
      check("evict_w2", rd(32'h88), 32'hCCCCCCCC);
      check("evict_w3", rd(32'h8C), 32'hDDDDDDDD);
      check("evict_type", last_ltype, 3'd1);
      check("evict_data", last_ldata, 128'h0);
      check("evict_opq", last_lopq, 8'hC3);

      // Backpressure on word 2 and on the line response
      wstall_word = 2; wstall_left = 3; lstall_left = 5;
      line_q.push_back(mk_lreq(3'd0, 8'h11, 32'h0000_1230, 128'h0));
      run_lines(3, 100, "bp_done");
      check("bp_nreq", wreq_line, 4);
      check("bp_data", last_ldata, 128'h44444444_33333333_22222222_11111111);
      wstall_word = -1;

      // Back-to-back reads
      for (int unsigned i = 0; i < 8; i++) mem[32'h2000 + 4 * i] = $urandom;
      last_lresp_cyc = -1;
      chk_b2b = 1'b1;
      line_q.push_back(mk_lreq(3'd0, 8'h21, 32'h0000_2000, 128'h0));
      line_q.push_back(mk_lreq(3'd0, 8'h22, 32'h0000_2018, 128'h0));
      run_lines(5, 200, "b2b_done");
      chk_b2b = 1'b0;

      // Reset in the middle of a read, with a word response still owed
      line_q.push_back(mk_lreq(3'd0, 8'h31, 32'h0000_2004, 128'h0));
      n = 0;
      while (!(inflight == 1 && wresp_line == 2 && resp_q.size() != 0) && n < 100) begin
         tick();
         n++;
      end
      check("rst_reach", n < 100, 1'b1);
      apply_reset();
      n = 0;
      while (resp_q.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      check("rst_drain", resp_q.size(), 0);
      repeat (3) tick();
      check("rst_no_lresp", n_lresp, 5);
      line_q.push_back(mk_lreq(3'd0, 8'h32, 32'h0000_1238, 128'h0));
      run_lines(6, 100, "post_rst_done");
      check("post_rst_data", last_ldata, 128'h44444444_33333333_22222222_11111111);

      // Random traffic with backpressure and variable memory latency
      for (int unsigned i = 0; i < 64; i++) mem[32'h0010_0000 + 4 * i] = $urandom;
      rand_bp = 1'b1;
      rand_dly = 1'b1;
      for (int i = 0; i < 40; i++) begin
         r = $urandom;
         a = 32'h0010_0000 | (r & 32'hFF);
         line_q.push_back(mk_lreq(3'($urandom_range(0, 1)), 8'($urandom), a,
                                  {$urandom, $urandom, $urandom, $urandom}));
      end
      run_lines(46, 40 * 80, "rand_done");
      check("rand_left", exp_l_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
